dmem_responder: RTL and testbench

//  Data-memory responder: the memory end of the pipeline's MEM-stage access interface.

---
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. It accepts one word access at a time,
// answers LATENCY cycles later and holds the pipeline through stall until then.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic [1:0]  dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Handshake: a request is taken when req_valid is high in IDLE. stall stays high
    // while req_valid is high and the access is not yet in RESP; rsp_valid marks the
    // single RESP cycle, and the pipeline advances on the edge that ends it.

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            mis_q, mis_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            enter_resp;
    logic            mem_we;
    logic            unused_addr;

    logic [31:0]     mem [DEPTH];

    assign unused_addr = ^req_addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    mis_d   = |req_addr[1:0];
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // cnt holds the BUSY cycles still to run; leave once it decrements to 0.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The *_d copies already carry the request when RESP is entered straight from IDLE.
    always_comb begin
        enter_resp = (state_d == RESP) && (state_q != RESP);
        mem_we     = enter_resp && we_d && !mis_d;
        rdata_d    = '0;
        err_d      = 1'b0;
        if (enter_resp) begin
            err_d = mis_d;
            if (!we_d && !mis_d) begin
                rdata_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; a write pending while reset is low is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign stall       = req_valid && (state_q != RESP);
    assign dbg_state_o = state_q;

    a_rsp_single_pulse: assert property (@(posedge clk) disable iff (!reset_n)
        rsp_valid |=> !rsp_valid);
    a_err_only_with_rsp: assert property (@(posedge clk) disable iff (!reset_n)
        rsp_err |-> rsp_valid);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=2 and one LATENCY=1 instance, checked every
// cycle against a transaction-level memory model plus directed literal expectations.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [2];
    logic        rv    [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        vo    [2];
    logic [31:0] rdo   [2];
    logic        erro  [2];
    logic        stallo[2];
    logic [1:0]  dbg   [2];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset_n(rstn[0]), .req_valid(rv[0]), .req_we(we[0]),
        .req_addr(addr[0]), .req_wdata(wdata[0]), .rsp_valid(vo[0]),
        .rsp_rdata(rdo[0]), .rsp_err(erro[0]), .stall(stallo[0]),
        .dbg_state_o(dbg[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(rstn[1]), .req_valid(rv[1]), .req_we(we[1]),
        .req_addr(addr[1]), .req_wdata(wdata[1]), .rsp_valid(vo[1]),
        .rsp_rdata(rdo[1]), .rsp_err(erro[1]), .stall(stallo[1]),
        .dbg_state_o(dbg[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: word storage plus at most one outstanding access per instance.
    logic [31:0] mmem  [2][DEPTH];
    bit          known [2][DEPTH];
    bit          p_vld [2];
    int          p_cyc [2];
    bit          p_we  [2];
    bit          p_mis [2];
    int          p_idx [2];
    logic [31:0] p_data[2];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k, input int lat);
        bit resp_now;
        if (!rstn[k]) begin
            p_vld[k] = 1'b0;
            check($sformatf("i%0d_rst_valid", k), 32'(vo[k]), 32'd0);
            check($sformatf("i%0d_rst_rdata", k), rdo[k], 32'd0);
            check($sformatf("i%0d_rst_err", k), 32'(erro[k]), 32'd0);
            check($sformatf("i%0d_rst_stall", k), 32'(stallo[k]), 32'(rv[k]));
            return;
        end
        resp_now = p_vld[k] && (cyc == p_cyc[k]);
        check($sformatf("i%0d_valid", k), 32'(vo[k]), 32'(resp_now));
        check($sformatf("i%0d_stall", k), 32'(stallo[k]), 32'(rv[k] && !resp_now));
        check($sformatf("i%0d_err", k), 32'(erro[k]), 32'(resp_now && p_mis[k]));
        if (resp_now) begin
            exp_q.delete();
            if (p_we[k] || p_mis[k]) exp_q.push_back(32'd0);
            else if (known[k][p_idx[k]]) exp_q.push_back(mmem[k][p_idx[k]]);
            if (exp_q.size() > 0) check($sformatf("i%0d_rdata", k), rdo[k], exp_q.pop_front());
            if (p_we[k] && !p_mis[k]) begin
                mmem[k][p_idx[k]]  = p_data[k];
                known[k][p_idx[k]] = 1'b1;
            end
            p_vld[k] = 1'b0;
        end else begin
            check($sformatf("i%0d_rdata_idle", k), rdo[k], 32'd0);
            if (!p_vld[k] && rv[k]) begin
                p_vld[k]  = 1'b1;
                p_cyc[k]  = cyc + lat;
                p_we[k]   = we[k];
                p_mis[k]  = |addr[k][1:0];
                p_idx[k]  = int'(addr[k][AW+1:2]);
                p_data[k] = wdata[k];
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, 2);
        model_step(1, 1);
        cyc++;
    end

    // Issue one access and hold req_valid until the response (or only for the accept
    // cycle when drop is set). lat_seen is cycles from the request to rsp_valid.
    task automatic do_req(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit drop, output int lat_seen, output int stall_n,
                          output logic [31:0] rd, output bit er);
        @(posedge clk);
        #1;
        rv[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        lat_seen = -1; stall_n = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stallo[k]) stall_n++;
            if (vo[k]) begin
                lat_seen = i; rd = rdo[k]; er = erro[k];
                break;
            end
            if (drop && i == 0) begin
                @(posedge clk);
                #1;
                rv[k] = 1'b0; wdata[k] = $urandom; addr[k] = $urandom;
            end
        end
        if (lat_seen < 0) begin
            total++; bad++;
            $display("FAIL i%0d_timeout: got no rsp_valid expected one within 40 cycles", k);
        end
        @(posedge clk);
        #1;
        rv[k] = 1'b0;
    endtask

    int          lat, sn;
    logic [31:0] rd;
    bit          er;
    logic [5:0]  sp, vp;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn[k] = 1'b0; rv[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
            p_vld[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_valid%0d", k), 32'(vo[k]), 32'd0);
            check($sformatf("reset_rdata%0d", k), rdo[k], 32'd0);
            check($sformatf("reset_err%0d", k), 32'(erro[k]), 32'd0);
            check($sformatf("reset_state%0d", k), 32'(dbg[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, sn, rd, er);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_stall_cycles", 32'(sn), 32'd2);
        check("t1_err", 32'(er), 32'd0);

        do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, sn, rd, er);
        check("t2_rdata", rd, 32'hDEADBEEF);
        check("t2_latency", 32'(lat), 32'd2);
        do_req(0, 1'b0, 32'h10 + DEPTH * 4, 32'h0, 1'b0, lat, sn, rd, er);
        check("t2_alias_rdata", rd, 32'hDEADBEEF);

        do_req(0, 1'b1, 32'h13, 32'h12345678, 1'b0, lat, sn, rd, er);
        check("t3_err", 32'(er), 32'd1);
        check("t3_wr_rdata", rd, 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, sn, rd, er);
        check("t3_kept", rd, 32'hDEADBEEF);
        do_req(0, 1'b0, 32'h11, 32'h0, 1'b0, lat, sn, rd, er);
        check("t3_misread_rdata", rd, 32'd0);
        check("t3_misread_err", 32'(er), 32'd1);

        do_req(0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b1, lat, sn, rd, er);
        check("t4_latency", 32'(lat), 32'd2);
        check("t4_stall_cycles", 32'(sn), 32'd1);
        do_req(0, 1'b0, 32'h40, 32'h0, 1'b0, lat, sn, rd, er);
        check("t4_latched_data", rd, 32'hCAFEF00D);

        do_req(0, 1'b1, 32'h20, 32'h11112222, 1'b0, lat, sn, rd, er);
        @(posedge clk);
        #1;
        rv[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        rstn[0] = 1'b0; rv[0] = 1'b0;
        #1;
        check("t5_valid", 32'(vo[0]), 32'd0);
        check("t5_rdata", rdo[0], 32'd0);
        check("t5_err", 32'(erro[0]), 32'd0);
        check("t5_state", 32'(dbg[0]), 32'd0);
        @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        do_req(0, 1'b0, 32'h20, 32'h0, 1'b0, lat, sn, rd, er);
        check("t5_old_data", rd, 32'h11112222);
        check("t5_not_aborted", 32'(rd == 32'hBAD0BAD0), 32'd0);

        do_req(1, 1'b1, 32'h80, 32'h5A5A5A5A, 1'b0, lat, sn, rd, er);
        check("t6_latency", 32'(lat), 32'd1);
        check("t6_stall_cycles", 32'(sn), 32'd1);
        @(posedge clk);
        #1;
        rv[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h80;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sp[5-i] = stallo[1];
            vp[5-i] = vo[1];
            if (vo[1]) check("t6_rdata", rdo[1], 32'h5A5A5A5A);
        end
        @(posedge clk);
        #1;
        rv[1] = 1'b0;
        check("t6_stall_pattern", 32'(sp), 32'(6'b101010));
        check("t6_valid_pattern", 32'(vp), 32'(6'b010101));

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 80; n++) begin
                logic [31:0] a;
                a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
                do_req(k, 1'($urandom_range(0, 1)), a, $urandom,
                       ($urandom_range(0, 3) == 0), lat, sn, rd, er);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
